// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. Free-running h/v counters give
//               the display block its pixel coordinates with zero latency.
//               Sync and blank are decoded from the counters and delayed by
//               PIPE_DLY enabled cycles, so they line up with pixel data that
//               arrives PIPE_DLY cycles after the coordinates. One output
//               register stage then drives the DAC.
//
// Ports       : vga_clock   - pixel clock, rising edge
//               rst_n       - asynchronous active-low reset
//               pix_en      - pixel-clock enable, all state advances on it
//               red_in      - [7:0] pixel red from the display block
//               green_in    - [7:0] pixel green from the display block
//               blue_in     - [7:0] pixel blue from the display block
//               hcount      - [9:0] current column
//               vcount      - [9:0] current line
//               frame_tick  - one-cycle pulse at the start of vertical blank
//               vga_r/g/b   - [7:0] registered colour to the DAC
//               vga_hs_n    - horizontal sync, active low
//               vga_vs_n    - vertical sync, active low
//               vga_blank_n - high while the pixel is visible
//
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_DLY = 1
) (
    input  logic       vga_clock,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       frame_tick,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs_n,
    output logic       vga_vs_n,
    output logic       vga_blank_n
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter guard (counters are 10 bits wide)
    // ------------------------------------------------------------------------
    generate
        if ((PIPE_DLY < 1) || (PIPE_DLY > 4) ||
            (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
            (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0) ||
            (H_ACTIVE < 1) || (V_ACTIVE < 1) ||
            (H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_params
            $error("vga_timing_gen: illegal parameter set");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [9:0]          hcount_q, hcount_d;
    logic [9:0]          vcount_q, vcount_d;
    logic                frame_tick_q, frame_tick_d;
    logic [PIPE_DLY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DLY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DLY-1:0] vis_pipe_q, vis_pipe_d;
    logic                hs_n_q, hs_n_d;
    logic                vs_n_q, vs_n_d;
    logic                blank_n_q, blank_n_d;
    logic [7:0]          r_q, r_d;
    logic [7:0]          g_q, g_d;
    logic [7:0]          b_q, b_d;

    logic                hs_raw;
    logic                vs_raw;
    logic                vis_raw;
    logic                vis_dly;

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hcount_q == 10'(H_TOTAL - 1)) begin
                hcount_d = 10'd0;
                if (vcount_q == 10'(V_TOTAL - 1)) begin
                    vcount_d = 10'd0;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Raw decode of the current counter position
    // ------------------------------------------------------------------------
    always_comb begin
        hs_raw  = !((hcount_q >= 10'(H_SYNC_START)) && (hcount_q < 10'(H_SYNC_END)));
        vs_raw  = !((vcount_q >= 10'(V_SYNC_START)) && (vcount_q < 10'(V_SYNC_END)));
        vis_raw = (hcount_q < 10'(H_ACTIVE)) && (vcount_q < 10'(V_ACTIVE));
    end

    // ------------------------------------------------------------------------
    // Delay line: stage 0 takes the raw decode, the last stage feeds the
    // output registers. Holds while pix_en is low.
    // ------------------------------------------------------------------------
    always_comb begin
        hs_pipe_d  = hs_pipe_q;
        vs_pipe_d  = vs_pipe_q;
        vis_pipe_d = vis_pipe_q;
        if (pix_en) begin
            hs_pipe_d[0]  = hs_raw;
            vs_pipe_d[0]  = vs_raw;
            vis_pipe_d[0] = vis_raw;
            for (int i = 1; i < PIPE_DLY; i++) begin
                hs_pipe_d[i]  = hs_pipe_q[i-1];
                vs_pipe_d[i]  = vs_pipe_q[i-1];
                vis_pipe_d[i] = vis_pipe_q[i-1];
            end
        end
    end

    assign vis_dly = vis_pipe_q[PIPE_DLY-1];

    // ------------------------------------------------------------------------
    // Output register stage and frame tick
    // ------------------------------------------------------------------------
    always_comb begin
        hs_n_d       = hs_n_q;
        vs_n_d       = vs_n_q;
        blank_n_d    = blank_n_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        frame_tick_d = frame_tick_q;
        if (pix_en) begin
            hs_n_d       = hs_pipe_q[PIPE_DLY-1];
            vs_n_d       = vs_pipe_q[PIPE_DLY-1];
            blank_n_d    = vis_dly;
            r_d          = vis_dly ? red_in   : 8'd0;
            g_d          = vis_dly ? green_in : 8'd0;
            b_d          = vis_dly ? blue_in  : 8'd0;
            // Armed by the enabled edge leaving (0, V_ACTIVE); cleared by the
            // next enabled edge, so it spans exactly one enabled cycle.
            frame_tick_d = (hcount_q == 10'd0) && (vcount_q == 10'(V_ACTIVE));
        end
    end

    always_ff @(posedge vga_clock or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q     <= 10'd0;
            vcount_q     <= 10'd0;
            frame_tick_q <= 1'b0;
            hs_pipe_q    <= {PIPE_DLY{1'b1}};
            vs_pipe_q    <= {PIPE_DLY{1'b1}};
            vis_pipe_q   <= {PIPE_DLY{1'b0}};
            hs_n_q       <= 1'b1;
            vs_n_q       <= 1'b1;
            blank_n_q    <= 1'b0;
            r_q          <= 8'd0;
            g_q          <= 8'd0;
            b_q          <= 8'd0;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            frame_tick_q <= frame_tick_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
            vis_pipe_q   <= vis_pipe_d;
            hs_n_q       <= hs_n_d;
            vs_n_q       <= vs_n_d;
            blank_n_q    <= blank_n_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    // The armed tick is only presented while the clock is enabled, so a
    // gated-off cycle never shows a pulse and the pulse lands on the first
    // enabled cycle after the counters pass (0, V_ACTIVE).
    assign frame_tick  = frame_tick_q & pix_en;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs_n    = hs_n_q;
    assign vga_vs_n    = vs_n_q;
    assign vga_blank_n = blank_n_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Bench for vga_timing_gen. Two instances share the stimulus,
//               one with PIPE_DLY=1 and one with PIPE_DLY=3, on a reduced
//               raster so many frames fit in a short run. Random pix_en
//               patterns, colours and resets; a raster-arithmetic reference
//               model feeds an expectation queue drained by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 4;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME  = HT * VT;
    localparam int CYCLES = 20000;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       bl;
    } regs_t;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       tick;
        regs_t      o1;
        regs_t      o3;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       pix_en;
    logic [7:0] red_in, green_in, blue_in;

    logic [9:0] hc1, vc1, hc3, vc3;
    logic       ft1, ft3;
    logic [7:0] r1, g1, b1, r3, g3, b3;
    logic       hs1, vs1, bl1, hs3, vs3, bl3;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_DLY(1)
    ) u_dut1 (
        .vga_clock(clk), .rst_n(rst_n), .pix_en(pix_en),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hcount(hc1), .vcount(vc1), .frame_tick(ft1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .vga_hs_n(hs1), .vga_vs_n(vs1), .vga_blank_n(bl1)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_DLY(3)
    ) u_dut3 (
        .vga_clock(clk), .rst_n(rst_n), .pix_en(pix_en),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hcount(hc3), .vcount(vc3), .frame_tick(ft3),
        .vga_r(r3), .vga_g(g3), .vga_b(b3),
        .vga_hs_n(hs3), .vga_vs_n(vs3), .vga_blank_n(bl3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: n = enabled edges since reset release. The counters
    // sit at raster position n; the registered outputs after edge n show the
    // decode of position n-1-PIPE_DLY with the colour present at that edge.
    // ------------------------------------------------------------------------
    int    n;
    logic  tick_pend;
    regs_t m1, m3;
    exp_t  q[$];
    int    checks   = 0;
    int    failures = 0;
    int    exp_ticks = 0;
    int    got_ticks = 0;
    bit    started  = 1'b0;
    bit    done     = 1'b0;

    function automatic regs_t reset_regs();
        regs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic regs_t raster_out(int cnt, int p, logic [7:0] r, logic [7:0] g, logic [7:0] b);
        regs_t o;
        int    src, h, v;
        logic  vis;
        src = cnt - 1 - p;
        if (src < 0) return reset_regs();
        h   = src % HT;
        v   = (src / HT) % VT;
        vis = (h < HA) && (v < VA);
        o.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        o.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        o.bl = vis;
        o.r  = vis ? r : 8'd0;
        o.g  = vis ? g : 8'd0;
        o.b  = vis ? b : 8'd0;
        return o;
    endfunction

    task automatic model_reset();
        n         = 0;
        tick_pend = 1'b0;
        m1        = reset_regs();
        m3        = reset_regs();
    endtask

    task automatic model_edge(input logic en, input logic rl,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        if (!rl) begin
            model_reset();
        end else if (en) begin
            tick_pend = ((n % FRAME) == VA * HT);
            n  = n + 1;
            m1 = raster_out(n, 1, r, g, b);
            m3 = raster_out(n, 3, r, g, b);
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus: drives inputs 2 time units after each rising edge, advances
    // the model for the edge just taken, then queues the expectation for the
    // cycle now starting.
    // ------------------------------------------------------------------------
    initial begin
        logic       cur_en, cur_rl;
        logic [7:0] cur_r, cur_g, cur_b;
        int         mode, rst_left;
        exp_t       e;

        rst_n = 1'b0; pix_en = 1'b0;
        red_in = 8'd0; green_in = 8'd0; blue_in = 8'd0;
        model_reset();
        cur_en = 1'b0; cur_rl = 1'b0; cur_r = 8'd0; cur_g = 8'd0; cur_b = 8'd0;
        mode = 1; rst_left = 3;

        for (int c = 0; c < CYCLES; c++) begin
            @(posedge clk);
            #2;
            model_edge(cur_en, cur_rl, cur_r, cur_g, cur_b);

            if (c % 600 == 0) mode = (c < 4000) ? 1 : int'($urandom_range(0, 2));
            if (rst_left > 0) begin
                rst_left--;
            end else if (c == 6000 || $urandom_range(0, 2999) == 0) begin
                rst_left = int'($urandom_range(0, 3));
            end
            cur_rl = (rst_left == 0);
            case (mode)
                0:       cur_en = ($urandom_range(0, 3) != 0);
                1:       cur_en = 1'b1;
                default: cur_en = (c % 2 == 0);
            endcase
            cur_r = 8'($urandom);
            cur_g = 8'($urandom);
            cur_b = 8'($urandom);

            rst_n    = cur_rl;
            pix_en   = cur_en;
            red_in   = cur_r;
            green_in = cur_g;
            blue_in  = cur_b;
            if (!cur_rl) model_reset();

            e.h    = 10'(n % HT);
            e.v    = 10'((n / HT) % VT);
            e.tick = tick_pend && cur_en && cur_rl;
            e.o1   = m1;
            e.o3   = m3;
            if (e.tick) exp_ticks++;
            q.push_back(e);
            started = 1'b1;
        end
        done = 1'b1;
    end

    // ------------------------------------------------------------------------
    // Monitor: samples on the falling edge, mid-cycle.
    // ------------------------------------------------------------------------
    initial begin
        exp_t  e;
        regs_t a1, a3;
        wait (started);
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                if (done) break;
                checks++;
                failures++;
                $display("FAIL queue_underflow t=%0t", $time);
            end else begin
                e  = q.pop_front();
                a1 = {r1, g1, b1, hs1, vs1, bl1};
                a3 = {r3, g3, b3, hs3, vs3, bl3};
                if (ft1) got_ticks++;

                checks++;
                if ({hc1, vc1, ft1} !== {e.h, e.v, e.tick}) begin
                    failures++;
                    $display("FAIL p1_counters t=%0t got h=%0d v=%0d tick=%b exp h=%0d v=%0d tick=%b",
                             $time, hc1, vc1, ft1, e.h, e.v, e.tick);
                end
                checks++;
                if ({hc3, vc3, ft3} !== {e.h, e.v, e.tick}) begin
                    failures++;
                    $display("FAIL p3_counters t=%0t got h=%0d v=%0d tick=%b exp h=%0d v=%0d tick=%b",
                             $time, hc3, vc3, ft3, e.h, e.v, e.tick);
                end
                checks++;
                if (a1 !== e.o1) begin
                    failures++;
                    $display("FAIL p1_outputs t=%0t got rgb=%h%h%h hs=%b vs=%b bl=%b exp rgb=%h%h%h hs=%b vs=%b bl=%b",
                             $time, a1.r, a1.g, a1.b, a1.hs, a1.vs, a1.bl,
                             e.o1.r, e.o1.g, e.o1.b, e.o1.hs, e.o1.vs, e.o1.bl);
                end
                checks++;
                if (a3 !== e.o3) begin
                    failures++;
                    $display("FAIL p3_outputs t=%0t got rgb=%h%h%h hs=%b vs=%b bl=%b exp rgb=%h%h%h hs=%b vs=%b bl=%b",
                             $time, a3.r, a3.g, a3.b, a3.hs, a3.vs, a3.bl,
                             e.o3.r, e.o3.g, e.o3.b, e.o3.hs, e.o3.vs, e.o3.bl);
                end
            end
        end

        checks++;
        if (got_ticks != exp_ticks) begin
            failures++;
            $display("FAIL tick_count got=%0d exp=%0d", got_ticks, exp_ticks);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound in case the clock or stimulus stalls.
    initial begin
        #((CYCLES + 100) * 10 * 2);
        $display("FAIL timeout t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
